// File: rtl/cfg_stream_loader.sv
// Configuration-bus initiator: parses a framed word stream (header, then addr/data pairs) and
// issues one config_valid strobe per pair. Define CFG_CHECKSUM_EN to require an XOR trailer word.
module cfg_stream_loader #(
   parameter logic [15:0] MAGIC     = 16'hC0F6,
   parameter int          ISSUE_GAP = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] config_addr,
   output logic [31:0] config_data,
   output logic        config_valid,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

`ifdef CFG_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_ADDR, S_DATA, S_ISSUE, S_GAP, S_DONE, S_CHECK
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_HEADER, S_ADDR, S_DATA, S_ISSUE, S_GAP, S_DONE
   } state_t;
`endif

   localparam logic [3:0] GAP_LAST = (ISSUE_GAP > 0) ? 4'(ISSUE_GAP - 1) : 4'd0;

   state_t      state_q, state_d;
   logic [15:0] remaining_q, remaining_d;
   logic [3:0]  gap_cnt_q, gap_cnt_d;
   logic [31:0] addr_hold_q, addr_hold_d;
   logic [31:0] cfg_addr_q, cfg_addr_d;
   logic [31:0] cfg_data_q, cfg_data_d;
   logic        error_q, error_d;
   logic [15:0] words_q, words_d;
`ifdef CFG_CHECKSUM_EN
   logic [31:0] csum_q, csum_d;
`endif
   logic        xfer;

   // Where a write goes once its strobe (and any trailing gap) is complete.
   function automatic state_t exit_state(input logic last_pair);
      if (last_pair) begin
`ifdef CFG_CHECKSUM_EN
         return S_CHECK;
`else
         return S_DONE;
`endif
      end
      return S_ADDR;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         gap_cnt_q   <= '0;
         addr_hold_q <= '0;
         cfg_addr_q  <= '0;
         cfg_data_q  <= '0;
         error_q     <= 1'b0;
         words_q     <= '0;
`ifdef CFG_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         gap_cnt_q   <= gap_cnt_d;
         addr_hold_q <= addr_hold_d;
         cfg_addr_q  <= cfg_addr_d;
         cfg_data_q  <= cfg_data_d;
         error_q     <= error_d;
         words_q     <= words_d;
`ifdef CFG_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   // in_ready depends only on the registered state, so upstream sees no in_valid->in_ready path.
   always_comb begin
      in_ready = (state_q == S_HEADER) || (state_q == S_ADDR) || (state_q == S_DATA);
`ifdef CFG_CHECKSUM_EN
      if (state_q == S_CHECK) in_ready = 1'b1;
`endif
   end

   assign xfer = in_valid & in_ready;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      gap_cnt_d   = gap_cnt_q;
      addr_hold_d = addr_hold_q;
      cfg_addr_d  = cfg_addr_q;
      cfg_data_d  = cfg_data_q;
      error_d     = error_q;
      words_d     = words_q;
`ifdef CFG_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_HEADER;
               error_d = 1'b0;
               words_d = '0;
            end
         end
         S_HEADER: begin
            if (xfer) begin
`ifdef CFG_CHECKSUM_EN
               csum_d = in_data;
`endif
               if (in_data[31:16] != MAGIC) begin
                  error_d = 1'b1;
                  state_d = S_DONE;
               end else if (in_data[15:0] == 16'd0) begin
                  state_d = S_DONE;
               end else begin
                  remaining_d = in_data[15:0];
                  state_d     = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            if (xfer) begin
               addr_hold_d = in_data;
`ifdef CFG_CHECKSUM_EN
               csum_d      = csum_q ^ in_data;
`endif
               state_d     = S_DATA;
            end
         end
         S_DATA: begin
            // The bus registers load here so the pair is already stable during the strobe.
            if (xfer) begin
               cfg_addr_d = addr_hold_q;
               cfg_data_d = in_data;
`ifdef CFG_CHECKSUM_EN
               csum_d     = csum_q ^ in_data;
`endif
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            remaining_d = remaining_q - 16'd1;
            words_d     = (words_q == 16'hFFFF) ? words_q : words_q + 16'd1;
            if (ISSUE_GAP > 0) begin
               gap_cnt_d = '0;
               state_d   = S_GAP;
            end else begin
               state_d = exit_state(remaining_q == 16'd1);
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = exit_state(remaining_q == 16'd0);
            else                       gap_cnt_d = gap_cnt_q + 4'd1;
         end
`ifdef CFG_CHECKSUM_EN
         S_CHECK: begin
            if (xfer) begin
               if (in_data != csum_q) error_d = 1'b1;
               state_d = S_DONE;
            end
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign config_addr  = cfg_addr_q;
   assign config_data  = cfg_data_q;
   assign config_valid = (state_q == S_ISSUE);
   assign busy         = (state_q != S_IDLE);
   assign done         = (state_q == S_DONE);
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: one instance with ISSUE_GAP=0, one with ISSUE_GAP=4.
module tb_cfg_stream_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst0, start0, in_valid0, in_ready0, cv0, busy0, done0, err0;
   logic [31:0] in_data0, ca0, cd0;
   logic [15:0] wl0;
   logic        rst1, start1, in_valid1, in_ready1, cv1, busy1, done1, err1;
   logic [31:0] in_data1, ca1, cd1;
   logic [15:0] wl1;

   int tests = 0;
   int fails = 0;
   int strobes0 = 0, strobes1 = 0, dups0 = 0, dups1 = 0;
   logic prev_cv0 = 1'b0, prev_cv1 = 1'b0;
   logic [31:0] fx0, fx1;
   int s_base;

   cfg_stream_loader #(.MAGIC(16'hC0F6), .ISSUE_GAP(0)) dut0 (
      .clk(clk), .reset(rst0), .start(start0), .in_data(in_data0), .in_valid(in_valid0),
      .in_ready(in_ready0), .config_addr(ca0), .config_data(cd0), .config_valid(cv0),
      .busy(busy0), .done(done0), .error(err0), .words_loaded(wl0));

   cfg_stream_loader #(.MAGIC(16'hC0F6), .ISSUE_GAP(4)) dut1 (
      .clk(clk), .reset(rst1), .start(start1), .in_data(in_data1), .in_valid(in_valid1),
      .in_ready(in_ready1), .config_addr(ca1), .config_data(cd1), .config_valid(cv1),
      .busy(busy1), .done(done1), .error(err1), .words_loaded(wl1));

   // Strobe monitor: counts config_valid cycles and flags any strobe longer than one cycle.
   always @(negedge clk) begin
      if (cv0) begin
         strobes0++;
         if (prev_cv0) dups0++;
      end
      if (cv1) begin
         strobes1++;
         if (prev_cv1) dups1++;
      end
      prev_cv0 = cv0;
      prev_cv1 = cv1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input int which);
      if (which == 0) begin start0 = 1'b1; fx0 = '0; end
      else            begin start1 = 1'b1; fx1 = '0; end
      tick();
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   // Present one word and hold it until it is accepted (bounded wait).
   task automatic send(input int which, input logic [31:0] w);
      logic ok;
      ok = 1'b0;
      if (which == 0) begin in_data0 = w; in_valid0 = 1'b1; end
      else            begin in_data1 = w; in_valid1 = 1'b1; end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if ((which == 0) ? in_ready0 : in_ready1) begin ok = 1'b1; break; end
      end
      if (ok) begin
         @(posedge clk);
         #1;
         if (which == 0) fx0 = fx0 ^ w;
         else            fx1 = fx1 ^ w;
      end
      check("send_accepted", {31'd0, ok}, 32'd1);
   endtask

   // From the cycle after the last strobe sequence, advance to the DONE state.
   task automatic finish_frame(input int which);
`ifdef CFG_CHECKSUM_EN
      send(which, (which == 0) ? fx0 : fx1);
`else
      tick();
`endif
      in_valid0 = 1'b0;
      in_valid1 = 1'b0;
   endtask

   initial begin
      rst0 = 1'b1; rst1 = 1'b1;
      start0 = 1'b0; start1 = 1'b0;
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      in_data0 = '0; in_data1 = '0;
      fx0 = '0; fx1 = '0;
      #12;
      check("rst_busy", {31'd0, busy0}, 32'd0);
      check("rst_outs", {ca0 | cd0}, 32'd0);
      check("rst_flags", {27'd0, cv0, done0, err0, in_ready0, busy1}, 32'd0);
      check("rst_words", {16'd0, wl0}, 32'd0);
      @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0;
      tick();
      check("idle_in_ready", {31'd0, in_ready0}, 32'd0);

      // Two-pair frame, no gap, in_valid continuously high.
      start_load(0);
      check("t1_busy", {31'd0, busy0}, 32'd1);
      check("t1_in_ready", {31'd0, in_ready0}, 32'd1);
      send(0, 32'hC0F60002);
      send(0, 32'h00010001);
      send(0, 32'hDEADBEEF);
      check("t1_cv_a", {31'd0, cv0}, 32'd1);
      check("t1_addr_a", ca0, 32'h00010001);
      check("t1_data_a", cd0, 32'hDEADBEEF);
      send(0, 32'h00020003);
      send(0, 32'h12345678);
      check("t1_cv_b", {31'd0, cv0}, 32'd1);
      check("t1_addr_b", ca0, 32'h00020003);
      check("t1_data_b", cd0, 32'h12345678);
      finish_frame(0);
      check("t1_done", {31'd0, done0}, 32'd1);
      check("t1_words", {16'd0, wl0}, 32'd2);
      check("t1_error", {31'd0, err0}, 32'd0);
      check("t1_hold_addr", ca0, 32'h00020003);
      tick();
      check("t1_done_pulse", {30'd0, done0, busy0}, 32'd0);
      check("t1_strobes", strobes0, 32'd2);

      // Bad magic: DONE right after the header, error sticky.
      s_base = strobes0;
      start_load(0);
      send(0, 32'hBEEF0001);
      in_valid0 = 1'b0;
      check("t2_done", {31'd0, done0}, 32'd1);
      check("t2_error", {31'd0, err0}, 32'd1);
      tick();
      check("t2_after", {29'd0, done0, in_ready0, busy0}, 32'd0);
      check("t2_error_sticky", {31'd0, err0}, 32'd1);
      check("t2_strobes", strobes0 - s_base, 32'd0);

      // Empty frame: start clears error, nothing written.
      start_load(0);
      check("t3_error_cleared", {31'd0, err0}, 32'd0);
      send(0, 32'hC0F60000);
      in_valid0 = 1'b0;
      check("t3_done", {31'd0, done0}, 32'd1);
      check("t3_words", {16'd0, wl0}, 32'd0);
      tick();
      check("t3_busy", {31'd0, busy0}, 32'd0);
      check("t3_strobes", strobes0 - s_base, 32'd0);

      // One pair with a 5-cycle stall before the data word and a start pulse mid-frame.
      start_load(0);
      send(0, 32'hC0F60001);
      send(0, 32'h00050007);
      in_valid0 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         start0 = (i == 2);
         tick();
      end
      start0 = 1'b0;
      check("t4_stall_ready", {30'd0, in_ready0, busy0}, 32'd3);
      check("t4_no_strobe", strobes0 - s_base, 32'd0);
      send(0, 32'hCAFEF00D);
      check("t4_cv", {31'd0, cv0}, 32'd1);
      check("t4_addr", ca0, 32'h00050007);
      check("t4_data", cd0, 32'hCAFEF00D);
      finish_frame(0);
      check("t4_done", {31'd0, done0}, 32'd1);
      check("t4_words", {16'd0, wl0}, 32'd1);
      tick();
      check("t4_idle", {31'd0, busy0}, 32'd0);
      check("t4_strobes", strobes0 - s_base, 32'd1);

      // ISSUE_GAP=4 instance: reset during the first gap, then a fresh frame.
      start_load(1);
      send(1, 32'hC0F60002);
      send(1, 32'h00110022);
      send(1, 32'h55AA55AA);
      in_valid1 = 1'b0;
      check("t5_cv", {31'd0, cv1}, 32'd1);
      check("t5_addr", ca1, 32'h00110022);
      tick();
      check("t5_gap", {30'd0, cv1, busy1}, 32'd1);
      #2 rst1 = 1'b1;
      #1;
      check("t5_async_flags", {27'd0, cv1, busy1, done1, err1, in_ready1}, 32'd0);
      check("t5_async_bus", ca1 | cd1, 32'd0);
      check("t5_async_words", {16'd0, wl1}, 32'd0);
      @(negedge clk);
      rst1 = 1'b0;
      repeat (12) tick();
      check("t5_no_second", strobes1, 32'd1);
      start_load(1);
      send(1, 32'hC0F60001);
      send(1, 32'h00330044);
      send(1, 32'h0BADCAFE);
      in_valid1 = 1'b0;
      check("t5b_cv", {31'd0, cv1}, 32'd1);
      check("t5b_data", cd1, 32'h0BADCAFE);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5b_gap_quiet", {30'd0, cv1, done1}, 32'd0);
      end
      finish_frame(1);
      check("t5b_done", {31'd0, done1}, 32'd1);
      check("t5b_words", {16'd0, wl1}, 32'd1);
      check("t5b_error", {31'd0, err1}, 32'd0);
      tick();
      check("t5b_strobes", strobes1, 32'd2);

`ifdef CFG_CHECKSUM_EN
      // Trailer = C0F60001 ^ 00010002 ^ 0000000F = C0F7000C.
      s_base = strobes0;
      start_load(0);
      send(0, 32'hC0F60001);
      send(0, 32'h00010002);
      send(0, 32'h0000000F);
      send(0, 32'hC0F7000C);
      in_valid0 = 1'b0;
      check("t6_good_done", {31'd0, done0}, 32'd1);
      check("t6_good_error", {31'd0, err0}, 32'd0);
      tick();
      start_load(0);
      send(0, 32'hC0F60001);
      send(0, 32'h00010002);
      send(0, 32'h0000000F);
      send(0, 32'hC0F7000D);
      in_valid0 = 1'b0;
      check("t6_bad_done", {31'd0, done0}, 32'd1);
      check("t6_bad_error", {31'd0, err0}, 32'd1);
      tick();
      check("t6_strobes", strobes0 - s_base, 32'd2);
`endif

      check("no_long_strobes", dups0 + dups1, 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
